sync_fifo_init: RTL and testbench

Single-clock FIFO whose storage is preloaded with a fixed pattern on reset: after reset it is full and holds entries 0,1,…,DEPTH-1 in read order. It supplies a ready-made token/index pool, such as free buffer addresses, to switch logic in the same clock domain, which can drain and refill it. Overflow and underflow attempts are rejected and flagged with one-cycle error pulses.

---
 rtl/sync_fifo_init_pkg.sv | 13 +
 rtl/sync_fifo_init_if.sv | 26 ++
 rtl/sync_fifo_init_mem.sv | 50 +++++
 rtl/sync_fifo_init.sv | 77 +++++++
 tb/tb_sync_fifo_init.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_init_pkg.sv
// rtl/sync_fifo_init_pkg.sv - shared sizes and preload pattern for the preloaded FIFO
package sync_fifo_init_pkg;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    // Entry i of the preload holds its own index, truncated to the data width.
    function automatic logic [DATA_W-1:0] init_val(input int unsigned i);
        return i[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo_init_if.sv
// rtl/sync_fifo_init_if.sv - write/read handshake bundle of the preloaded FIFO
// master: the client (drives requests and write data)
// slave:  the FIFO (drives flags, read data and error pulses)
interface sync_fifo_init_if;
    import sync_fifo_init_pkg::*;

    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_full;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_wr_err;
    logic              fifo_rd_err;

    modport master (
        output fifo_wr_en, fifo_wr_data, fifo_rd_en,
        input  fifo_full, fifo_rd_data, fifo_empty, fifo_wr_err, fifo_rd_err
    );

    modport slave (
        input  fifo_wr_en, fifo_wr_data, fifo_rd_en,
        output fifo_full, fifo_rd_data, fifo_empty, fifo_wr_err, fifo_rd_err
    );

endinterface

// File: rtl/sync_fifo_init_mem.sv
// rtl/sync_fifo_init_mem.sv - register array with write port, registered read port and reset preload
// clk, rst_n          : clock, synchronous active-low reset (loads init pattern, clears rd_data)
// wr_en/wr_addr/wr_data : write port, one entry per cycle
// rd_en/rd_addr       : read request; rd_data updates on the accepting edge and holds otherwise
module sync_fifo_init_mem
    import sync_fifo_init_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = rd_data_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        // Read and write never target the same slot in one cycle: equal
        // pointers mean full or empty, where only one side is accepted.
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= init_val(i);
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_init.sv
// rtl/sync_fifo_init.sv - single-clock FIFO that comes out of reset full of indices 0..DEPTH-1
// clk, rst_n : clock, synchronous active-low reset
// fifo       : slave side of the handshake bundle (requests in; flags, data, error pulses out)
module sync_fifo_init
    import sync_fifo_init_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_init_if.slave  fifo
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_err_q, rd_err_d;
    logic              wr_ok;
    logic              rd_ok;

    // Acceptance depends only on the occupancy at the start of the cycle,
    // so a full FIFO rejects a write even while a read frees a slot.
    always_comb begin
        wr_ok    = fifo.fifo_wr_en && (count_q != COUNT_FULL);
        rd_ok    = fifo.fifo_rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_err_d = fifo.fifo_wr_en && !wr_ok;
        rd_err_d = fifo.fifo_rd_en && !rd_ok;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= COUNT_FULL;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    sync_fifo_init_mem u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (fifo.fifo_wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (fifo.fifo_rd_data)
    );

    assign fifo.fifo_full   = (count_q == COUNT_FULL);
    assign fifo.fifo_empty  = (count_q == '0);
    assign fifo.fifo_wr_err = wr_err_q;
    assign fifo.fifo_rd_err = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_init.sv
// tb/tb_sync_fifo_init.sv - self-checking bench for sync_fifo_init
module tb_sync_fifo_init;
    import sync_fifo_init_pkg::*;

    logic clk;
    logic rst_n;

    sync_fifo_init_if fifo_if ();

    sync_fifo_init dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fifo  (fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Reference: a queue of stored values plus the registered outputs.
    int q[$];
    int m_rd_data;
    int m_wr_err;
    int m_rd_err;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(i % (1 << DATA_W));
        m_rd_data = 0;
        m_wr_err  = 0;
        m_rd_err  = 0;
    endtask

    task automatic model_edge(input bit w, input int d, input bit r);
        int  cnt;
        bit  w_ok;
        bit  r_ok;
        cnt  = q.size();
        w_ok = w && (cnt != DEPTH);
        r_ok = r && (cnt != 0);
        if (r_ok) m_rd_data = q.pop_front();
        if (w_ok) q.push_back(d);
        m_wr_err = (w && !w_ok) ? 1 : 0;
        m_rd_err = (r && !r_ok) ? 1 : 0;
    endtask

    // One clock: drive, clock edge, advance the model.
    task automatic step(input bit w, input int d, input bit r);
        fifo_if.fifo_wr_en   = w;
        fifo_if.fifo_wr_data = DATA_W'(d);
        fifo_if.fifo_rd_en   = r;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge(w, d, r);
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("full",    int'(fifo_if.fifo_full),    (q.size() == DEPTH) ? 1 : 0);
            chk("empty",   int'(fifo_if.fifo_empty),   (q.size() == 0) ? 1 : 0);
            chk("rd_data", int'(fifo_if.fifo_rd_data), m_rd_data);
            chk("wr_err",  int'(fifo_if.fifo_wr_err),  m_wr_err);
            chk("rd_err",  int'(fifo_if.fifo_rd_err),  m_rd_err);
        end
    end

    initial begin
        int first_rd;
        rst_n = 1'b0;
        fifo_if.fifo_wr_en   = 1'b0;
        fifo_if.fifo_wr_data = '0;
        fifo_if.fifo_rd_en   = 1'b0;
        model_reset();

        // Reset held 20 cycles with noisy inputs that must be ignored.
        for (int i = 0; i < 20; i++) step(1'b1, 5, 1'b1);
        rst_n = 1'b1;
        chk_en = 1;
        chk("rst_full",    int'(fifo_if.fifo_full), 1);
        chk("rst_empty",   int'(fifo_if.fifo_empty), 0);
        chk("rst_rd_data", int'(fifo_if.fifo_rd_data), 0);
        chk("rst_wr_err",  int'(fifo_if.fifo_wr_err), 0);
        chk("rst_rd_err",  int'(fifo_if.fifo_rd_err), 0);

        // Overflow right after reset.
        step(1'b1, 'h2A, 1'b0);
        chk("ovf_wr_err", int'(fifo_if.fifo_wr_err), 1);
        chk("ovf_full",   int'(fifo_if.fifo_full), 1);
        step(1'b0, 0, 1'b0);
        chk("ovf_wr_err_clr", int'(fifo_if.fifo_wr_err), 0);

        // Drain the preload.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 0, 1'b1);
            chk("drain_data", int'(fifo_if.fifo_rd_data), i);
            chk("drain_rd_err", int'(fifo_if.fifo_rd_err), 0);
            if (i == 0) chk("drain_full_drop", int'(fifo_if.fifo_full), 0);
        end
        chk("drain_empty", int'(fifo_if.fifo_empty), 1);

        // Underflow.
        step(1'b0, 0, 1'b1);
        chk("udf_rd_err", int'(fifo_if.fifo_rd_err), 1);
        chk("udf_hold",   int'(fifo_if.fifo_rd_data), 31);
        step(1'b0, 0, 1'b0);
        chk("udf_rd_err_clr", int'(fifo_if.fifo_rd_err), 0);

        // Empty with both requests: write wins, read rejected.
        step(1'b1, 17, 1'b1);
        chk("emp_both_rd_err", int'(fifo_if.fifo_rd_err), 1);
        chk("emp_both_empty",  int'(fifo_if.fifo_empty), 0);
        step(1'b0, 0, 1'b1);
        chk("emp_both_data", int'(fifo_if.fifo_rd_data), 17);

        // Refill with 40..71 mod 64.
        for (int i = 40; i < 72; i++) step(1'b1, i % 64, 1'b0);
        chk("refill_full", int'(fifo_if.fifo_full), 1);

        // Simultaneous read/write across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom_range(63), 1'b1);
            if (i == 0) begin
                first_rd = 40;
                chk("conc_first_data", int'(fifo_if.fifo_rd_data), first_rd);
                chk("conc_wr_err",     int'(fifo_if.fifo_wr_err), 1);
            end
            chk("conc_not_full", int'(fifo_if.fifo_full), 0);
        end
        for (int i = 0; i < 40; i++) step(1'b0, 0, 1'b1);

        // Random traffic, biased per phase toward filling or draining.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 120; i++) begin
                bit w;
                bit r;
                w = ($urandom_range(99) < ((p % 2 == 0) ? 75 : 30));
                r = ($urandom_range(99) < ((p % 2 == 0) ? 30 : 75));
                step(w, $urandom_range(63), r);
            end
        end

        // Mid-operation reset after 5 reads.
        rst_n = 1'b0;
        step(1'b0, 0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1);
        rst_n = 1'b0;
        step(1'b1, 9, 1'b1);
        rst_n = 1'b1;
        chk("mid_rst_full", int'(fifo_if.fifo_full), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b1);
            chk("mid_rst_data", int'(fifo_if.fifo_rd_data), i);
        end

        step(1'b0, 0, 1'b0);
        @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
